// File: rtl/median_select_ctrl.sv
// Iterative median search on one buffered window: load samples, then repeat partition
// passes against a pivot, narrowing [vlo,vhi] until rank k lands in the equal bucket.
module median_select_ctrl #(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int MEDIAN_POS    = BUFF_SIZE / 2,
  parameter int INIT_PIVOT    = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic [3:0] m_passes,
  output logic       busy
);
  localparam int IDX_W = $clog2(BUFF_SIZE);
  localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(BUFF_SIZE - 1);
  localparam logic [BUFF_SIZE_BIT-1:0] K_INIT     = BUFF_SIZE_BIT'(MEDIAN_POS);
  localparam logic [7:0]               PIVOT_INIT = 8'(INIT_PIVOT);

  typedef enum logic [1:0] {ST_LOAD, ST_SCAN, ST_DECIDE, ST_OUT} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [7:0]               vlo_q, vlo_d, vhi_q, vhi_d, pivot_q, pivot_d;
  logic [BUFF_SIZE_BIT-1:0] k_q, k_d;
  logic [BUFF_SIZE_BIT-1:0] lower_q, lower_d, equal_q, equal_d, larger_q, larger_d;
  logic [7:0]               min_lo_q, min_lo_d, max_lo_q, max_lo_d;
  logic [7:0]               min_hi_q, min_hi_d, max_hi_q, max_hi_d;
  logic [3:0]               passes_q, passes_d, m_passes_q, m_passes_d;
  logic [7:0]               m_data_q, m_data_d;
  logic [7:0]               sample_mem_q [BUFF_SIZE];

  logic                     wr_en, clear_cnt, in_range;
  logic [7:0]               samp, lo_mid, hi_mid;
  logic [8:0]               lo_sum, hi_sum;
  logic [BUFF_SIZE_BIT-1:0] le_sum;

  assign samp     = sample_mem_q[rd_idx_q];
  assign in_range = (samp >= vlo_q) && (samp <= vhi_q);
  assign le_sum   = lower_q + equal_q;
  assign lo_sum   = {1'b0, max_lo_q} + {1'b0, min_lo_q};
  assign hi_sum   = {1'b0, max_hi_q} + {1'b0, min_hi_q};
  assign lo_mid   = lo_sum[8:1];
  assign hi_mid   = hi_sum[8:1];

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    vlo_d      = vlo_q;
    vhi_d      = vhi_q;
    pivot_d    = pivot_q;
    k_d        = k_q;
    lower_d    = lower_q;
    equal_d    = equal_q;
    larger_d   = larger_q;
    min_lo_d   = min_lo_q;
    max_lo_d   = max_lo_q;
    min_hi_d   = min_hi_q;
    max_hi_d   = max_hi_q;
    passes_d   = passes_q;
    m_data_d   = m_data_q;
    m_passes_d = m_passes_q;
    wr_en      = 1'b0;
    clear_cnt  = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d   = ST_SCAN;
            clear_cnt = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (in_range) begin
          if (samp < pivot_q) begin
            lower_d  = lower_q + 1'b1;
            min_lo_d = (samp < min_lo_q) ? samp : min_lo_q;
            max_lo_d = (samp > max_lo_q) ? samp : max_lo_q;
          end else if (samp == pivot_q) begin
            equal_d = equal_q + 1'b1;
          end else begin
            larger_d = larger_q + 1'b1;
            min_hi_d = (samp < min_hi_q) ? samp : min_hi_q;
            max_hi_d = (samp > max_hi_q) ? samp : max_hi_q;
          end
        end
        rd_idx_d = rd_idx_q + 1'b1;
        if (rd_idx_q == LAST_IDX) state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
        passes_d = (passes_q == 4'hF) ? 4'hF : passes_q + 4'd1;
        if (lower_q > k_q) begin
          vhi_d     = pivot_q - 8'd1;
          pivot_d   = lo_mid;
          state_d   = ST_SCAN;
          clear_cnt = 1'b1;
        end else if (le_sum > k_q) begin
          m_data_d   = pivot_q;
          m_passes_d = passes_d;
          state_d    = ST_OUT;
        end else begin
          // Rank k is re-expressed relative to the surviving upper range.
          k_d       = k_q - le_sum;
          vlo_d     = pivot_q + 8'd1;
          pivot_d   = hi_mid;
          state_d   = ST_SCAN;
          clear_cnt = 1'b1;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d  = ST_LOAD;
          wr_idx_d = '0;
          vlo_d    = 8'd0;
          vhi_d    = 8'd255;
          k_d      = K_INIT;
          pivot_d  = PIVOT_INIT;
          passes_d = 4'd0;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    if (clear_cnt) begin
      rd_idx_d = '0;
      lower_d  = '0;
      equal_d  = '0;
      larger_d = '0;
      min_lo_d = 8'd255;
      max_lo_d = 8'd0;
      min_hi_d = 8'd255;
      max_hi_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      vlo_q      <= 8'd0;
      vhi_q      <= 8'd255;
      pivot_q    <= PIVOT_INIT;
      k_q        <= K_INIT;
      lower_q    <= '0;
      equal_q    <= '0;
      larger_q   <= '0;
      min_lo_q   <= 8'd255;
      max_lo_q   <= 8'd0;
      min_hi_q   <= 8'd255;
      max_hi_q   <= 8'd0;
      passes_q   <= 4'd0;
      m_data_q   <= 8'd0;
      m_passes_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      vlo_q      <= vlo_d;
      vhi_q      <= vhi_d;
      pivot_q    <= pivot_d;
      k_q        <= k_d;
      lower_q    <= lower_d;
      equal_q    <= equal_d;
      larger_q   <= larger_d;
      min_lo_q   <= min_lo_d;
      max_lo_q   <= max_lo_d;
      min_hi_q   <= min_hi_d;
      max_hi_q   <= max_hi_d;
      passes_q   <= passes_d;
      m_data_q   <= m_data_d;
      m_passes_q <= m_passes_d;
    end
  end

  // Sample storage carries no reset; it is always fully rewritten before a scan.
  always_ff @(posedge clk) begin
    if (wr_en) sample_mem_q[wr_idx_q] <= s_data;
  end

  assign s_ready  = (state_q == ST_LOAD);
  assign m_valid  = (state_q == ST_OUT);
  assign busy     = (state_q == ST_SCAN) || (state_q == ST_DECIDE);
  assign m_data   = m_data_q;
  assign m_passes = m_passes_q;
endmodule

// File: tb/tb_median_select_ctrl.sv
// Directed and randomized checks of median_select_ctrl with an 8-sample window.
module tb_median_select_ctrl;
  localparam int N = 8;
  localparam int K = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'd0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [3:0] m_passes;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] win [N];
  int         lat;
  logic [7:0] res_data;
  logic [3:0] res_passes;

  median_select_ctrl #(.BUFF_SIZE(N), .MEDIAN_POS(K), .INIT_PIVOT(128)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_passes(m_passes),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_median();
    logic [7:0] a [N];
    logic [7:0] t;
    for (int i = 0; i < N; i++) a[i] = win[i];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[K];
  endfunction

  task automatic set_win(input logic [63:0] packed_w);
    for (int i = 0; i < N; i++) win[i] = packed_w[63-8*i -: 8];
  endtask

  // Drives the window; returns after the edge that accepts the last beat.
  task automatic load_window(input bit gaps);
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = win[i];
      @(posedge clk); #1;
      if (gaps) begin
        s_valid = 1'b0;
        s_data  = 8'hAA;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
    s_data  = 8'h55;
  endtask

  // lat counts edges from the last-beat edge (which counts as 1) to m_valid; -1 on timeout.
  task automatic wait_result();
    lat = 1;
    while (!m_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!m_valid) lat = -1;
    res_data   = m_data;
    res_passes = m_passes;
  endtask

  task automatic accept();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({s_ready, m_valid, busy, m_data, m_passes} !== {1'b1, 1'b0, 1'b0, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b data=%0d passes=%0d want 1 0 0 0 0",
               s_ready, m_valid, busy, m_data, m_passes);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b want 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_basic();
    set_win({8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4});
    load_window(1'b0);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got busy=%b rdy=%b want 1 0", busy, s_ready);
    end
    wait_result();
    checks++;
    if (lat !== 19) begin
      errors++;
      $display("FAIL basic_latency got %0d want 19", lat);
    end
    checks++;
    if (res_data !== 8'd5 || res_passes !== 4'd2) begin
      errors++;
      $display("FAIL basic_result got data=%0d passes=%0d want 5 2", res_data, res_passes);
    end
    accept();
  endtask

  task automatic test_uniform();
    logic [7:0] vals [4];
    logic [7:0] exp_p [4];
    vals[0] = 8'd7;   exp_p[0] = 8'd2;
    vals[1] = 8'd255; exp_p[1] = 8'd2;
    vals[2] = 8'd0;   exp_p[2] = 8'd2;
    vals[3] = 8'd128; exp_p[3] = 8'd1;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) win[i] = vals[t];
      load_window(1'b0);
      wait_result();
      checks++;
      if (lat < 0 || res_data !== vals[t] || {4'd0, res_passes} !== exp_p[t]) begin
        errors++;
        $display("FAIL uniform_%0d got data=%0d passes=%0d lat=%0d want data=%0d passes=%0d",
                 vals[t], res_data, res_passes, lat, vals[t], exp_p[t]);
      end
      accept();
    end
  endtask

  task automatic test_backpressure();
    int bad;
    set_win({8'd70, 8'd20, 8'd80, 8'd40, 8'd10, 8'd60, 8'd30, 8'd50});
    load_window(1'b0);
    wait_result();
    checks++;
    if (lat < 0 || res_data !== 8'd50 || res_passes !== 4'd5) begin
      errors++;
      $display("FAIL bp_result got data=%0d passes=%0d lat=%0d want 50 5", res_data, res_passes, lat);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b1 || m_data !== 8'd50 || m_passes !== 4'd5 || s_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
    end
    accept();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0 1", m_valid, s_ready);
    end
    set_win({8'd200, 8'd100, 8'd150, 8'd50, 8'd250, 8'd0, 8'd175, 8'd125});
    load_window(1'b0);
    wait_result();
    checks++;
    if (lat < 0 || res_data !== 8'd150) begin
      errors++;
      $display("FAIL bp_next got data=%0d lat=%0d want 150", res_data, lat);
    end
    accept();
  endtask

  task automatic test_gaps_and_reset();
    set_win({8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4});
    load_window(1'b1);
    wait_result();
    checks++;
    if (lat < 0 || res_data !== 8'd5 || res_passes !== 4'd2) begin
      errors++;
      $display("FAIL gaps_result got data=%0d passes=%0d lat=%0d want 5 2", res_data, res_passes, lat);
    end
    accept();
    set_win({8'd90, 8'd91, 8'd92, 8'd93, 8'd94, 8'd95, 8'd96, 8'd97});
    load_window(1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midscan_busy got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, m_valid, busy, m_data, m_passes} !== {1'b1, 1'b0, 1'b0, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL midscan_reset got rdy=%b vld=%b busy=%b data=%0d passes=%0d want 1 0 0 0 0",
               s_ready, m_valid, busy, m_data, m_passes);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_win({8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4});
    load_window(1'b0);
    wait_result();
    checks++;
    if (lat !== 19 || res_data !== 8'd5 || res_passes !== 4'd2) begin
      errors++;
      $display("FAIL after_reset got data=%0d passes=%0d lat=%0d want 5 2 19", res_data, res_passes, lat);
    end
    accept();
  endtask

  task automatic test_random();
    int bad_data, bad_passes;
    logic [7:0] exp;
    bad_data = 0;
    bad_passes = 0;
    for (int w = 0; w < 400; w++) begin
      for (int i = 0; i < N; i++)
        win[i] = (w % 3 == 0) ? 8'($urandom_range(0, 7) * 36) : 8'($urandom_range(0, 255));
      exp = ref_median();
      load_window(w % 5 == 0);
      wait_result();
      if (lat < 0 || res_data !== exp) begin
        bad_data++;
        if (bad_data < 5)
          $display("FAIL random_data window %0d got %0d want %0d lat=%0d", w, res_data, exp, lat);
      end
      if (res_passes > 4'd10) bad_passes++;
      if (lat < 0) break;
      accept();
    end
    checks++;
    if (bad_data !== 0) begin
      errors++;
      $display("FAIL random_data_total got %0d wrong windows want 0", bad_data);
    end
    checks++;
    if (bad_passes !== 0) begin
      errors++;
      $display("FAIL random_passes got %0d windows over 10 passes want 0", bad_passes);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_uniform();
    test_backpressure();
    test_gaps_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
